frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
- Double-buffered framebuffer controller sitting directly downstream of the voxel column renderer.
- Absorbs the renderer's pixel writes (coords, 3-bit colour, write enable) into the back bank.
- Serves the VGA scan-out stage from the front bank.
- Owns the frame handshake: clears the back bank to sky, pulses render_ack to start a frame, waits for render_done, then swaps banks at vertical blank.

Parameters:
H_RES, 320, visible columns
V_RES, 240, visible rows
SKY_COLOR, 3'b011, clear colour written to every back-bank pixel before each frame
CLEAR_EN, 1, 1 = clear back bank before each render_ack; 0 = skip straight to ACK

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
coords_in  in  screenXY  renderer pixel coordinate (x 0..319, y 0..239)
color_in  in  3  renderer pixel colour
we_in  in  1  renderer write enable (may stay high for several cycles on one pixel)
render_done  in  1  one-cycle pulse from renderer: frame complete
render_ack  out  1  one-cycle pulse: back bank ready, renderer may start
vblank  in  1  high during VGA vertical blanking
rd_x  in  10  scan-out column
rd_y  in  10  scan-out row
rd_color  out  3  front-bank pixel at (rd_x, rd_y), 2-cycle latency
front_sel  out  1  bank currently displayed
busy_clear  out  1  high while clearing the back bank

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: front_sel=0, render_ack=0, rd_color=0, busy_clear=0, state=CLEAR, clr_addr=0.
  - Reset mid-frame abandons the frame. Back bank (1) is re-cleared; front contents are undefined until the first swap.
- Address rule: addr = y*320 + x, computed as (y<<8)+(y<<6)+x.
  - 17-bit fb_addr_t; maximum value 76799.
  - No multiplier is used.
- Back bank index is always ~front_sel.
- CLEAR state:
  - busy_clear=1.
  - Writes SKY_COLOR to back[clr_addr] and increments clr_addr, one pixel per cycle.
  - When clr_addr==76799 is written, go to ACK. The clear takes exactly 76800 cycles.
  - If CLEAR_EN=0, CLEAR lasts one cycle with no writes.
- ACK state: render_ack=1 for exactly one cycle, then RENDER.
- RENDER state:
  - Any cycle with we_in=1 and x<H_RES and y<V_RES writes color_in to back[addr]. Out-of-range writes are dropped silently.
  - Repeated writes to the same pixel are harmless.
  - render_done=1 goes to WAIT_VBL. A write coincident with render_done is still committed, because the renderer raises its final we and done together.
- WAIT_VBL state:
  - Writes are ignored.
  - Waits for a rising edge of vblank (registered previous value), then goes to SWAP.
  - If vblank is already high on entry, it waits for the next rising edge. A swap mid-blank is forbidden.
- SWAP state: front_sel toggles. Then go to CLEAR (or ACK if CLEAR_EN=0).
- Writes in CLEAR, ACK, WAIT_VBL and SWAP are ignored. A render_done outside RENDER is ignored.
- Read path:
  - Cycle 1: register the address and an in-range flag (rd_x<320 and rd_y<240), plus the current front_sel.
  - Cycle 2: read both banks and mux by the registered front_sel. rd_color = in-range ? q : 0.
  - The front bank is never written, so reads and writes never conflict.
  - A swap takes effect for a read whose address is registered after the toggle.
- Bank RAM: simple dual-port, one write port and one read port per bank, registered read, inferred block RAM, 76800x3.

Decomposition:
- Add to structs.sv:
  - fb_addr_t (17-bit)
  - constants FB_H_RES=320, FB_V_RES=240, FB_PIXELS=76800
  - the fb_state enum (CLEAR, ACK, RENDER, WAIT_VBL, SWAP)
- Sub-module fb_bank_ram (wraddr, wrdata, we, rdaddr, q), instantiated twice.
- Write-port and read-address steering stay in frame_buffer_ctrl.

Test Plan:
- Reset, then run free with vblank low -> busy_clear=1 for 76800 cycles, render_ack pulses once at cycle 76801 after reset release, front_sel=0.
- After ack, write (x=10, y=20, colour 5), pulse render_done, raise vblank -> front_sel=1 one cycle after the edge. A later read at (10,20) returns 5 two cycles after the address; read (11,20) returns 3'b011.
- During RENDER, write x=320,y=5 and x=5,y=240 -> no effect: after swap both (5,5) and (319,239) read SKY_COLOR, and no RAM write strobe is seen.
- render_done with vblank already high -> no swap until vblank falls and rises again. A we_in pulse during WAIT_VBL does not alter the back bank.
- we_in and render_done high in the same cycle at (319,239) colour 7 -> after swap, (319,239) reads 7.
- Assert Reset halfway through a RENDER -> front_sel=0, CLEAR restarts at clr_addr=0, and the next render_ack arrives 76800 cycles later.

Source files
------------

// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and constants for the double-buffered framebuffer controller.
package frame_buffer_ctrl_pkg;

    localparam int unsigned FB_H_RES  = 320;
    localparam int unsigned FB_V_RES  = 240;
    localparam int unsigned FB_PIXELS = 76800;

    typedef logic [16:0] fb_addr_t;

    // Renderer pixel coordinate.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } screenXY;

    typedef enum logic [2:0] {
        CLEAR,
        ACK,
        RENDER,
        WAIT_VBL,
        SWAP
    } fb_state_e;

    // y*320 + x built from shifts: 320 = 256 + 64.
    function automatic fb_addr_t fb_addr(input logic [9:0] x, input logic [9:0] y);
        fb_addr_t w_y;
        w_y = {7'd0, y};
        return (w_y << 8) + (w_y << 6) + {7'd0, x};
    endfunction

endpackage

// File: rtl/frame_buffer_ctrl_bank_ram.sv
// One framebuffer bank: simple dual-port RAM with registered read.
module fb_bank_ram
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FB_PIXELS,
    parameter int unsigned DW    = 3
) (
    input  logic          Clk,
    input  fb_addr_t      wraddr,
    input  logic [DW-1:0] wrdata,
    input  logic          we,
    input  fb_addr_t      rdaddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] r_mem [DEPTH];

    // Write port and registered read port share the clock but never the same bank half.
    always_ff @(posedge Clk) begin
        if (we) begin
            r_mem[wraddr] <= wrdata;
        end
        q <= r_mem[rdaddr];
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered framebuffer: renderer writes the back bank, scan-out reads the front bank,
// and the frame handshake (clear, ack, render, wait for vblank, swap) is sequenced here.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int unsigned H_RES     = FB_H_RES,
    parameter int unsigned V_RES     = FB_V_RES,
    parameter logic [2:0]  SKY_COLOR = 3'b011,
    parameter bit          CLEAR_EN  = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  screenXY    coords_in,
    input  logic [2:0] color_in,
    input  logic       we_in,
    input  logic       render_done,
    output logic       render_ack,
    input  logic       vblank,
    input  logic [9:0] rd_x,
    input  logic [9:0] rd_y,
    output logic [2:0] rd_color,
    output logic       front_sel,
    output logic       busy_clear
);

    localparam logic [9:0] H_LIM    = 10'(H_RES);
    localparam logic [9:0] V_LIM    = 10'(V_RES);
    localparam fb_addr_t   CLR_LAST = fb_addr_t'(FB_PIXELS - 1);

    fb_state_e  r_state, w_state_d;
    fb_addr_t   r_clr_addr;
    logic       r_front_sel;
    logic       r_vblank_prev;

    logic       w_vbl_rise;
    logic       w_pix_in_range;
    fb_addr_t   w_pix_addr;
    logic       w_wr_en;
    fb_addr_t   w_wr_addr;
    logic [2:0] w_wr_data;

    fb_addr_t   r_rd_addr;
    logic       r_rd_in_range, r_rd_sel;
    logic       r_rd_in_range2, r_rd_sel2;
    logic       w_rd_in_range;
    logic [2:0] w_q0, w_q1;

    assign w_vbl_rise     = vblank & ~r_vblank_prev;
    assign w_pix_in_range = (coords_in.x < H_LIM) && (coords_in.y < V_LIM);
    assign w_pix_addr     = fb_addr(coords_in.x, coords_in.y);
    assign w_rd_in_range  = (rd_x < H_LIM) && (rd_y < V_LIM);

    // State, clear counter, bank select and vblank edge history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= CLEAR;
            r_clr_addr    <= '0;
            r_front_sel   <= 1'b0;
            r_vblank_prev <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_vblank_prev <= vblank;
            if (CLEAR_EN && r_state == CLEAR) begin
                // Wrap to zero so the next CLEAR starts at the first pixel.
                r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + 17'd1;
            end
            if (r_state == SWAP) begin
                r_front_sel <= ~r_front_sel;
            end
        end
    end

    // Next-state decode and back-bank write-port steering.
    always_comb begin
        w_state_d = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = r_clr_addr;
        w_wr_data = SKY_COLOR;
        unique case (r_state)
            CLEAR: begin
                if (!CLEAR_EN) begin
                    w_state_d = ACK;
                end else begin
                    w_wr_en = 1'b1;
                    if (r_clr_addr == CLR_LAST) begin
                        w_state_d = ACK;
                    end
                end
            end
            ACK: w_state_d = RENDER;
            RENDER: begin
                // A final write arriving with render_done is still committed.
                if (we_in && w_pix_in_range) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_pix_addr;
                    w_wr_data = color_in;
                end
                if (render_done) begin
                    w_state_d = WAIT_VBL;
                end
            end
            WAIT_VBL: begin
                if (w_vbl_rise) begin
                    w_state_d = SWAP;
                end
            end
            SWAP: w_state_d = CLEAR_EN ? CLEAR : ACK;
            default: w_state_d = CLEAR;
        endcase
    end

    // Read pipeline: stage 1 latches address, range and bank; stage 2 aligns with RAM data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_addr      <= '0;
            r_rd_in_range  <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_rd_in_range2 <= 1'b0;
            r_rd_sel2      <= 1'b0;
        end else begin
            r_rd_addr      <= w_rd_in_range ? fb_addr(rd_x, rd_y) : '0;
            r_rd_in_range  <= w_rd_in_range;
            r_rd_sel       <= r_front_sel;
            r_rd_in_range2 <= r_rd_in_range;
            r_rd_sel2      <= r_rd_sel;
        end
    end

    // Back bank is ~front_sel, so only that bank sees the write strobe.
    fb_bank_ram u_bank0 (
        .Clk    (Clk),
        .wraddr (w_wr_addr),
        .wrdata (w_wr_data),
        .we     (w_wr_en & r_front_sel),
        .rdaddr (r_rd_addr),
        .q      (w_q0)
    );

    fb_bank_ram u_bank1 (
        .Clk    (Clk),
        .wraddr (w_wr_addr),
        .wrdata (w_wr_data),
        .we     (w_wr_en & ~r_front_sel),
        .rdaddr (r_rd_addr),
        .q      (w_q1)
    );

    assign rd_color   = r_rd_in_range2 ? (r_rd_sel2 ? w_q1 : w_q0) : 3'b000;
    assign front_sel  = r_front_sel;
    assign render_ack = (r_state == ACK);
    // Held low while reset is asserted even though the state already sits in CLEAR.
    assign busy_clear = CLEAR_EN && (r_state == CLEAR) && !Reset;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl: clear timing, render/swap handshake, read path.
module tb_frame_buffer_ctrl;
    import frame_buffer_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    screenXY    coords_in;
    logic [2:0] color_in;
    logic       we_in, render_done, render_ack, vblank;
    logic [9:0] rd_x, rd_y;
    logic [2:0] rd_color;
    logic       front_sel, busy_clear;

    frame_buffer_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .coords_in   (coords_in),
        .color_in    (color_in),
        .we_in       (we_in),
        .render_done (render_done),
        .render_ack  (render_ack),
        .vblank      (vblank),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_color    (rd_color),
        .front_sel   (front_sel),
        .busy_clear  (busy_clear)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x; int y; int c; int we; int done; int vbl; int exp_we;
    } wr_vec_t;
    typedef struct {
        int x; int y; int exp;
    } rd_vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle / busy / ack counters sampled mid-cycle; bench works with differences.
    int cyc = 0, busy_cnt = 0, ack_cnt = 0, ack_cyc = 0;
    always @(negedge Clk) begin
        cyc = cyc + 1;
        if (busy_clear) busy_cnt = busy_cnt + 1;
        if (render_ack) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    // Read scoreboard: expected pushed at issue, observed captured two edges later.
    int       issued = 0;
    int       exp_q[$];
    logic [2:0] obs [64];
    int       obs_wr = 0;
    int       mon_d1 = 0, mon_d2 = 0, mon_prev2 = 0;
    always @(posedge Clk) begin
        mon_prev2 = mon_d2;
        mon_d2    = mon_d1;
        mon_d1    = issued;
        if (mon_d2 != mon_prev2) begin
            #1;
            if (obs_wr < 64) obs[obs_wr] = rd_color;
            obs_wr = obs_wr + 1;
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Waits (bounded) for the next render_ack; returns its cycle and busy count since call.
    task automatic wait_ack(output int at_cyc, output int busy);
        int b_cyc, b_busy, b_ack;
        b_cyc  = cyc;
        b_busy = busy_cnt;
        b_ack  = ack_cnt;
        while (ack_cnt == b_ack && (cyc - b_cyc) < 80000) step();
        at_cyc = (ack_cnt == b_ack) ? -1 : ack_cyc - b_cyc;
        busy   = busy_cnt - b_busy;
    endtask

    task automatic issue_read(input rd_vec_t v);
        rd_x = 10'(v.x);
        rd_y = 10'(v.y);
        exp_q.push_back(v.exp);
        issued++;
        step();
    endtask

    wr_vec_t wr_tab[6];
    rd_vec_t rd_tab[8];

    initial begin
        int at, busy, b_ack, first, n;

        wr_tab[0] = '{10,  20,  5, 1, 0, 0, 1};
        wr_tab[1] = '{320, 5,   2, 1, 0, 0, 0};
        wr_tab[2] = '{5,   240, 2, 1, 0, 0, 0};
        wr_tab[3] = '{10,  20,  5, 1, 0, 0, 1};
        wr_tab[4] = '{0,   0,   0, 0, 0, 1, 0};
        wr_tab[5] = '{319, 239, 7, 1, 1, 1, 1};

        rd_tab[0] = '{10,  20,  5};
        rd_tab[1] = '{11,  20,  3};
        rd_tab[2] = '{5,   5,   3};
        rd_tab[3] = '{319, 239, 7};
        rd_tab[4] = '{320, 5,   0};
        rd_tab[5] = '{5,   240, 0};
        rd_tab[6] = '{0,   0,   3};
        rd_tab[7] = '{319, 0,   3};

        Reset = 1'b1; coords_in = '0; color_in = '0; we_in = 1'b0;
        render_done = 1'b0; vblank = 1'b0; rd_x = '0; rd_y = '0;
        repeat (3) step();
        check("reset front_sel", int'(front_sel), 0);
        check("reset render_ack", int'(render_ack), 0);
        check("reset busy_clear", int'(busy_clear), 0);
        check("reset rd_color", int'(rd_color), 0);

        // Initial clear from reset.
        Reset = 1'b0;
        b_ack = ack_cnt;
        wait_ack(at, busy);
        check("first ack cycle", at, 76801);
        check("first clear busy cycles", busy, 76800);
        check("front_sel after clear", int'(front_sel), 0);

        // Frame A render writes (now in RENDER).
        for (int i = 0; i < 6; i++) begin
            coords_in.x = 10'(wr_tab[i].x);
            coords_in.y = 10'(wr_tab[i].y);
            color_in    = 3'(wr_tab[i].c);
            we_in       = wr_tab[i].we[0];
            render_done = wr_tab[i].done[0];
            vblank      = wr_tab[i].vbl[0];
            #1;
            check($sformatf("write strobe %0d", i), int'(dut.w_wr_en), wr_tab[i].exp_we);
            step();
        end
        we_in = 1'b0; render_done = 1'b0;
        check("single ack pulse", ack_cnt - b_ack, 1);
        check("state WAIT_VBL", int'(dut.r_state), int'(WAIT_VBL));

        // vblank already high on entry: no swap; stray write ignored.
        coords_in.x = 10'd11; coords_in.y = 10'd20; color_in = 3'd6; we_in = 1'b1;
        #1;
        check("WAIT_VBL write strobe", int'(dut.w_wr_en), 0);
        step();
        we_in = 1'b0;
        repeat (3) step();
        check("no swap while vblank high", int'(front_sel), 0);
        vblank = 1'b0;
        repeat (3) step();
        check("no swap after vblank fall", int'(front_sel), 0);
        vblank = 1'b1;
        step();
        check("front_sel at edge detect", int'(front_sel), 0);
        step();
        check("front_sel after swap", int'(front_sel), 1);

        // Second clear starts now; stray render_done must be ignored.
        first = cyc;
        b_ack = ack_cnt;
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        vblank = 1'b0;
        for (int i = 0; i < 8; i++) issue_read(rd_tab[i]);
        n = 0;
        while (obs_wr < issued && n < 10) begin
            step();
            n++;
        end
        check("read results collected", obs_wr, issued);
        for (int i = 0; i < 8 && i < obs_wr; i++) begin
            check($sformatf("read (%0d,%0d)", rd_tab[i].x, rd_tab[i].y),
                  int'(obs[i]), exp_q.pop_front());
        end
        while (ack_cnt == b_ack && (cyc - first) < 80000) step();
        check("second ack cycle", (ack_cnt == b_ack) ? -1 : ack_cyc - first, 76801);

        // Reset in the middle of RENDER.
        coords_in.x = 10'd1; coords_in.y = 10'd1; color_in = 3'd4; we_in = 1'b1;
        #1;
        check("render write strobe", int'(dut.w_wr_en), 1);
        step();
        we_in = 1'b0;
        Reset = 1'b1;
        step();
        check("mid-frame reset front_sel", int'(front_sel), 0);
        check("mid-frame reset clr_addr", int'(dut.r_clr_addr), 0);
        check("mid-frame reset state", int'(dut.r_state), int'(CLEAR));
        check("mid-frame reset busy_clear", int'(busy_clear), 0);
        Reset = 1'b0;
        b_ack = ack_cnt;
        wait_ack(at, busy);
        check("post-reset ack cycle", at, 76801);
        check("post-reset busy cycles", busy, 76800);
        repeat (3) step();
        check("post-reset single ack", ack_cnt - b_ack, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
